// File: rtl/traffic_pkg.sv
// Shared light encodings, phase IDs and nominal dwell times for the junction controller and its monitor.
// Pure definitions: no latency, no backpressure.
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    typedef enum logic [2:0] {
        P_NONE = 3'd0,
        P1     = 3'd1,
        P2     = 3'd2,
        P3     = 3'd3,
        P4     = 3'd4,
        P5     = 3'd5,
        P6     = 3'd6
    } phase_e;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } lights_t;

    localparam int DWELL_P1_DEF = 8;
    localparam int DWELL_P2_DEF = 3;
    localparam int DWELL_P3_DEF = 6;
    localparam int DWELL_P4_DEF = 3;
    localparam int DWELL_P5_DEF = 4;
    localparam int DWELL_P6_DEF = 3;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            P1:      next_phase = P2;
            P2:      next_phase = P3;
            P3:      next_phase = P4;
            P4:      next_phase = P5;
            P5:      next_phase = P6;
            P6:      next_phase = P1;
            default: next_phase = P_NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light buses in, checker status out; master = controller/bench side, slave = monitor.
// No handshake: buses are sampled every cycle, so there is no backpressure.
interface traffic_light_monitor_if;
    logic        clr_err;
    logic [2:0]  light_M1;
    logic [2:0]  light_M2;
    logic [2:0]  light_MT;
    logic [2:0]  light_S;
    logic [2:0]  phase;
    logic        locked;
    logic        err_encoding;
    logic        err_conflict;
    logic        err_sequence;
    logic        err_timing;
    logic        fault;
    logic [15:0] cycle_count;

    modport master (
        output clr_err, light_M1, light_M2, light_MT, light_S,
        input  phase, locked, err_encoding, err_conflict, err_sequence,
               err_timing, fault, cycle_count
    );

    modport slave (
        input  clr_err, light_M1, light_M2, light_MT, light_S,
        output phase, locked, err_encoding, err_conflict, err_sequence,
               err_timing, fault, cycle_count
    );
endinterface

// File: rtl/light_phase_decoder.sv
// Maps the four light buses to a phase ID and flags encoding/conflict problems.
// Combinational, zero latency; no backpressure.
module light_phase_decoder
    import traffic_pkg::*;
(
    input  logic [2:0] i_m1,
    input  logic [2:0] i_m2,
    input  logic [2:0] i_mt,
    input  logic [2:0] i_s,
    output phase_e     o_phase,
    output logic       o_onehot_ok,
    output logic       o_conflict
);

    logic w_nr_m1, w_nr_m2, w_nr_mt, w_nr_s;

    // Non-red means the red bit is clear, so malformed buses also count as open.
    assign w_nr_m1 = ~i_m1[2];
    assign w_nr_m2 = ~i_m2[2];
    assign w_nr_mt = ~i_mt[2];
    assign w_nr_s  = ~i_s[2];

    assign o_onehot_ok = $onehot(i_m1) && $onehot(i_m2) && $onehot(i_mt) && $onehot(i_s);
    assign o_conflict  = (w_nr_s && (w_nr_m1 || w_nr_m2 || w_nr_mt)) || (w_nr_mt && w_nr_m2);

    always_comb begin
        o_phase = P_NONE;
        case ({i_m1, i_m2, i_mt, i_s})
            {GREEN,  GREEN,  RED,    RED   }: o_phase = P1;
            {GREEN,  YELLOW, RED,    RED   }: o_phase = P2;
            {GREEN,  RED,    GREEN,  RED   }: o_phase = P3;
            {YELLOW, RED,    YELLOW, RED   }: o_phase = P4;
            {RED,    RED,    RED,    GREEN }: o_phase = P5;
            {RED,    RED,    RED,    YELLOW}: o_phase = P6;
            default:                          o_phase = P_NONE;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the controller's light buses: decode, legality, order, dwell; sticky flags.
// Latency 2 edges (sample, then check); passive, never stalls the controller.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int DWELL_P1 = DWELL_P1_DEF,
    parameter int DWELL_P2 = DWELL_P2_DEF,
    parameter int DWELL_P3 = DWELL_P3_DEF,
    parameter int DWELL_P4 = DWELL_P4_DEF,
    parameter int DWELL_P5 = DWELL_P5_DEF,
    parameter int DWELL_P6 = DWELL_P6_DEF,
    parameter int CNT_W    = 5
)
(
    input  logic                    clk,
    input  logic                    rst,
    traffic_light_monitor_if.slave  bus
);

    lights_t          r_lights;
    logic             r_clr;
    mon_state_e       r_state;
    phase_e           r_phase;
    logic [CNT_W-1:0] r_dwell;
    logic             r_err_enc, r_err_conf, r_err_seq, r_err_tim;
    logic [15:0]      r_cycle_cnt;

    phase_e           w_phase;
    logic             w_onehot_ok, w_conflict;
    mon_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_dwell_nxt, w_dwell_inc;
    logic             w_set_enc, w_set_conf, w_set_seq, w_set_tim;
    logic             w_wrap, w_cc_inc;

    function automatic logic [CNT_W-1:0] dwell_of(input phase_e p);
        case (p)
            P1:      dwell_of = CNT_W'(DWELL_P1);
            P2:      dwell_of = CNT_W'(DWELL_P2);
            P3:      dwell_of = CNT_W'(DWELL_P3);
            P4:      dwell_of = CNT_W'(DWELL_P4);
            P5:      dwell_of = CNT_W'(DWELL_P5);
            P6:      dwell_of = CNT_W'(DWELL_P6);
            default: dwell_of = '0;
        endcase
    endfunction

    // Idle reset value is all-red so the first checked sample decodes cleanly to phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lights <= '{m1: RED, m2: RED, mt: RED, s: RED};
            r_clr    <= 1'b0;
        end else begin
            r_lights <= '{m1: bus.light_M1, m2: bus.light_M2, mt: bus.light_MT, s: bus.light_S};
            r_clr    <= bus.clr_err;
        end
    end

    light_phase_decoder u_dec (
        .i_m1        (r_lights.m1),
        .i_m2        (r_lights.m2),
        .i_mt        (r_lights.mt),
        .i_s         (r_lights.s),
        .o_phase     (w_phase),
        .o_onehot_ok (w_onehot_ok),
        .o_conflict  (w_conflict)
    );

    assign w_set_enc   = ~w_onehot_ok;
    assign w_set_conf  = w_conflict;
    assign w_dwell_inc = (r_dwell == {CNT_W{1'b1}}) ? r_dwell : r_dwell + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_set_seq   = 1'b0;
        w_set_tim   = 1'b0;
        w_wrap      = 1'b0;
        if (w_phase == P_NONE) begin
            w_dwell_nxt = '0;
            w_state_nxt = ST_SYNC;
        end else if (w_phase == r_phase) begin
            w_dwell_nxt = w_dwell_inc;
            // Equality, not >=, so an overstay is reported on one sample only.
            w_set_tim   = (r_state == ST_TRACK) &&
                          (w_dwell_inc == dwell_of(r_phase) + CNT_W'(1));
        end else begin
            w_dwell_nxt = CNT_W'(1);
            if (r_phase != P_NONE) begin
                w_state_nxt = ST_TRACK;
                w_set_seq   = (w_phase != next_phase(r_phase));
                if (r_state == ST_TRACK) begin
                    w_set_tim = (r_dwell < dwell_of(r_phase));
                    w_wrap    = (r_phase == P6) && (w_phase == P1);
                end
            end
        end
    end

    assign w_cc_inc = w_wrap && !(w_set_enc || w_set_conf || w_set_seq || w_set_tim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SYNC;
            r_phase     <= P_NONE;
            r_dwell     <= '0;
            r_err_enc   <= 1'b0;
            r_err_conf  <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_tim   <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase;
            r_dwell    <= w_dwell_nxt;
            r_err_enc  <= (r_err_enc  && !r_clr) || w_set_enc;
            r_err_conf <= (r_err_conf && !r_clr) || w_set_conf;
            r_err_seq  <= (r_err_seq  && !r_clr) || w_set_seq;
            r_err_tim  <= (r_err_tim  && !r_clr) || w_set_tim;
            if (w_cc_inc && (r_cycle_cnt != 16'hFFFF))
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign bus.phase        = r_phase;
    assign bus.locked       = (r_state == ST_TRACK);
    assign bus.err_encoding = r_err_enc;
    assign bus.err_conflict = r_err_conf;
    assign bus.err_sequence = r_err_seq;
    assign bus.err_timing   = r_err_tim;
    assign bus.fault        = r_err_enc || r_err_conf || r_err_seq || r_err_tim;
    assign bus.cycle_count  = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed light-bus sequences with hand-computed expectations, checked through a scoreboard queue.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    localparam logic [11:0] PAT1 = {GREEN,  GREEN,  RED,    RED   };
    localparam logic [11:0] PAT2 = {GREEN,  YELLOW, RED,    RED   };
    localparam logic [11:0] PAT3 = {GREEN,  RED,    GREEN,  RED   };
    localparam logic [11:0] PAT4 = {YELLOW, RED,    YELLOW, RED   };
    localparam logic [11:0] PAT5 = {RED,    RED,    RED,    GREEN };
    localparam logic [11:0] PAT6 = {RED,    RED,    RED,    YELLOW};
    localparam logic [11:0] CONF = {GREEN,  RED,    RED,    GREEN };
    localparam logic [11:0] BADE = {GREEN,  RED,    3'b011, RED   };

    typedef struct {
        int          due;
        int          id;
        logic [24:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pcnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   nid = 0;
    exp_t sb[$];

    traffic_light_monitor_if tlm_if ();

    traffic_light_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (tlm_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic push(input logic [2:0] ph, input logic lk, input logic [3:0] er,
                        input logic [15:0] cc, input int due);
        exp_t e;
        e.due = due;
        e.id  = nid;
        e.exp = {ph, lk, er, |er, cc};
        nid++;
        sb.push_back(e);
    endtask

    // Drive a pattern for n samples; expectation is for the last of them.
    task automatic row(input logic [11:0] pat, input int n, input logic clr,
                       input logic [2:0] ph, input logic lk, input logic [3:0] er,
                       input logic [15:0] cc);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            {tlm_if.light_M1, tlm_if.light_M2, tlm_if.light_MT, tlm_if.light_S} = pat;
            tlm_if.clr_err = clr;
        end
        push(ph, lk, er, cc, pcnt + 2);
    endtask

    // Reset is checked within the same clock period it is raised.
    task automatic reset_seq();
        @(posedge clk);
        #2;
        rst = 1'b1;
        {tlm_if.light_M1, tlm_if.light_M2, tlm_if.light_MT, tlm_if.light_S} = PAT1;
        tlm_if.clr_err = 1'b0;
        push(3'd0, 1'b0, 4'b0000, 16'd0, pcnt);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic nom_cycle(input int p1n, input logic lk1, input logic [15:0] cc,
                             input logic [3:0] er);
        row(PAT1, p1n, 1'b0, 3'd1, lk1,  er, cc);
        row(PAT2, 3,   1'b0, 3'd2, 1'b1, er, cc);
        row(PAT3, 6,   1'b0, 3'd3, 1'b1, er, cc);
        row(PAT4, 3,   1'b0, 3'd4, 1'b1, er, cc);
        row(PAT5, 4,   1'b0, 3'd5, 1'b1, er, cc);
        row(PAT6, 3,   1'b0, 3'd6, 1'b1, er, cc);
    endtask

    initial begin
        exp_t        e;
        logic [24:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due <= pcnt) begin
                e = sb.pop_front();
                checks++;
                act = {tlm_if.phase, tlm_if.locked, tlm_if.err_encoding, tlm_if.err_conflict,
                       tlm_if.err_sequence, tlm_if.err_timing, tlm_if.fault, tlm_if.cycle_count};
                if (e.due != pcnt) begin
                    errors++;
                    $display("FAIL chk%0d: sample missed (due edge %0d, now %0d)", e.id, e.due, pcnt);
                end else if (act !== e.exp) begin
                    errors++;
                    $display("FAIL chk%0d: got ph=%0d lk=%b err=%b flt=%b cc=%0d, want ph=%0d lk=%b err=%b flt=%b cc=%0d",
                             e.id, act[24:22], act[21], act[20:17], act[16], act[15:0],
                             e.exp[24:22], e.exp[21], e.exp[20:17], e.exp[16], e.exp[15:0]);
                end
            end
        end
    end

    initial begin
        tlm_if.clr_err  = 1'b0;
        {tlm_if.light_M1, tlm_if.light_M2, tlm_if.light_MT, tlm_if.light_S} = PAT1;

        // Three nominal cycles from reset: first P1 partial and unlocked.
        reset_seq();
        nom_cycle(7, 1'b0, 16'd0, 4'b0000);
        nom_cycle(8, 1'b1, 16'd1, 4'b0000);
        nom_cycle(8, 1'b1, 16'd2, 4'b0000);

        // P3 overstay: 6 samples clean, 7th flags timing.
        row(PAT1, 8, 1'b0, 3'd1, 1'b1, 4'b0000, 16'd3);
        row(PAT2, 3, 1'b0, 3'd2, 1'b1, 4'b0000, 16'd3);
        row(PAT3, 6, 1'b0, 3'd3, 1'b1, 4'b0000, 16'd3);
        row(PAT3, 1, 1'b0, 3'd3, 1'b1, 4'b0001, 16'd3);
        row(PAT4, 3, 1'b1, 3'd4, 1'b1, 4'b0000, 16'd3);
        row(PAT5, 4, 1'b0, 3'd5, 1'b1, 4'b0000, 16'd3);
        row(PAT6, 3, 1'b0, 3'd6, 1'b1, 4'b0000, 16'd3);
        row(PAT1, 8, 1'b0, 3'd1, 1'b1, 4'b0000, 16'd4);

        // Skip P2->P4, then clear on the next sample.
        row(PAT2, 3, 1'b0, 3'd2, 1'b1, 4'b0000, 16'd4);
        row(PAT4, 1, 1'b0, 3'd4, 1'b1, 4'b0010, 16'd4);
        row(PAT4, 1, 1'b1, 3'd4, 1'b1, 4'b0000, 16'd4);
        row(PAT4, 1, 1'b0, 3'd4, 1'b1, 4'b0000, 16'd4);
        row(PAT5, 4, 1'b0, 3'd5, 1'b1, 4'b0000, 16'd4);

        // Short P6 with clr on the same sample: error wins, no count.
        row(PAT6, 2, 1'b0, 3'd6, 1'b1, 4'b0000, 16'd4);
        row(PAT1, 1, 1'b1, 3'd1, 1'b1, 4'b0001, 16'd4);
        row(PAT1, 7, 1'b0, 3'd1, 1'b1, 4'b0001, 16'd4);
        row(PAT2, 1, 1'b1, 3'd2, 1'b1, 4'b0000, 16'd4);
        row(PAT2, 2, 1'b0, 3'd2, 1'b1, 4'b0000, 16'd4);

        // Side green against main green, then relock after next change.
        row(CONF, 1, 1'b0, 3'd0, 1'b0, 4'b0100, 16'd4);
        row(PAT3, 6, 1'b0, 3'd3, 1'b0, 4'b0100, 16'd4);
        row(PAT4, 3, 1'b0, 3'd4, 1'b1, 4'b0100, 16'd4);

        // Malformed MT bus, then resume legal run with sticky flags.
        row(BADE, 1, 1'b0, 3'd0, 1'b0, 4'b1100, 16'd4);
        row(PAT5, 4, 1'b0, 3'd5, 1'b0, 4'b1100, 16'd4);
        row(PAT6, 3, 1'b0, 3'd6, 1'b1, 4'b1100, 16'd4);
        row(PAT1, 8, 1'b0, 3'd1, 1'b1, 4'b1100, 16'd5);
        row(PAT2, 3, 1'b0, 3'd2, 1'b1, 4'b1100, 16'd5);
        row(PAT3, 6, 1'b0, 3'd3, 1'b1, 4'b1100, 16'd5);
        row(PAT4, 3, 1'b0, 3'd4, 1'b1, 4'b1100, 16'd5);
        row(PAT5, 2, 1'b0, 3'd5, 1'b1, 4'b1100, 16'd5);

        // Reset in the middle of P5, then a clean run.
        repeat (2) @(posedge clk);
        reset_seq();
        nom_cycle(7, 1'b0, 16'd0, 4'b0000);
        row(PAT1, 1, 1'b0, 3'd1, 1'b1, 4'b0000, 16'd1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the receiving end of the four 3-bit one-hot light buses driven by the junction traffic controller.
- Decodes the bus pattern back into phase ID P1..P6 and checks encoding legality, conflicting greens, phase order and per-phase dwell time.
- Reports sticky error flags and a completed-cycle count.
- Sits beside the controller on the same clk/rst; drives FPGA debug LEDs / bench scoreboard.

Parameters:
DWELL_P1, 8, cycles controller holds P1 (M1 G, M2 G, MT R, S R)
DWELL_P2, 3, cycles in P2 (M1 G, M2 Y, MT R, S R)
DWELL_P3, 6, cycles in P3 (M1 G, M2 R, MT G, S R)
DWELL_P4, 3, cycles in P4 (M1 Y, M2 R, MT Y, S R)
DWELL_P5, 4, cycles in P5 (M1 R, M2 R, MT R, S G)
DWELL_P6, 3, cycles in P6 (M1 R, M2 R, MT R, S Y)
CNT_W, 5, dwell counter width; saturates at 2^CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  reset
clr_err  in  1  synchronous clear of sticky error flags
light_M1  in  3  main road 1 lights: 001 green, 010 yellow, 100 red
light_M2  in  3  main road 2 lights
light_MT  in  3  main through lights
light_S  in  3  side road lights
phase  out  3  decoded phase 1..6; 0 = no legal pattern
locked  out  1  1 = TRACK state
err_encoding  out  1  sticky: some bus not one-hot (incl. 000)
err_conflict  out  1  sticky: conflicting non-red approaches
err_sequence  out  1  sticky: illegal phase transition
err_timing  out  1  sticky: dwell short or overstayed
fault  out  1  OR of the four error flags
cycle_count  out  16  completed P6->P1 cycles, saturating at 0xFFFF

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk. On reset all outputs are 0, the state is SYNC, the dwell counter is 0 and the previous phase is 0.
- Stage 1 registers all four buses every cycle.
- Stage 2 decodes and checks; it updates phase and the error flags.
- Latency: buses present at edge k are reflected in the outputs after edge k+1.
- Decode: exact match to one of the six patterns above gives 1..6; any other pattern gives 0.
- err_encoding sets when any registered bus is not exactly one-hot.
- err_conflict sets when:
  - S is non-red while any of M1/M2/MT is non-red, or
  - MT is non-red while M2 is non-red.
  - It is checked on raw one-hot fields and is independent of decode.
- Dwell counter:
  - Counts consecutive samples with an unchanged nonzero phase.
  - Loads 1 on the first sample of a new phase.
  - Saturates at the CNT_W maximum.
- State SYNC:
  - Phase checks are disabled until a phase change between two nonzero phases is seen.
  - err_sequence is checked on that first change.
  - Dwell of the phase being left is not checked (partial).
  - Go to TRACK on that change.
- State TRACK, on each change from phase a to nonzero phase b:
  - b != successor(a) (1->2->3->4->5->6->1) sets err_sequence.
  - dwell(a) < DWELL_Pa sets err_timing.
  - The transition 6->1 increments cycle_count, only if no error flag sets on that sample.
- Overstay: in TRACK, the dwell counter reaching DWELL_Pcur+1 sets err_timing at that sample. It is flagged once, not re-evaluated per cycle.
- Decoded phase 0 in any state:
  - Dwell counter clears.
  - Previous phase becomes 0.
  - State returns to SYNC, and locked drops on the same update.
- Error flags are sticky until rst or clr_err.
- clr_err and a new error on the same sample: the error wins and the flag stays 1.
- clr_err does not touch state, phase or cycle_count.
- Reset mid-cycle: everything returns to reset values immediately. The first post-reset sample (controller in P1) lands in SYNC, so the first partial P1 is unchecked.

Decomposition:
- Shared package traffic_pkg holds:
  - Light encodings GREEN=3'b001, YELLOW=3'b010, RED=3'b100.
  - Phase IDs P_NONE=0..P6=6.
  - Default dwell constants.
- The controller also uses this package.
- Sub-module light_phase_decoder: combinational; four buses in; phase, onehot_ok and conflict out. It is reusable by the bench scoreboard.

Test Plan:
- Drive the legal pattern sequence with nominal dwells 8/3/6/3/4/3 for 3 full cycles after rst -> locked=1 from the first P1->P2; all errors 0; cycle_count=2 (the first partial P1 is not counted until 6->1 occurs twice after lock... count equals the number of 6->1 transitions = 2).
- Hold P3 for 7 samples in TRACK -> err_timing=1 two edges after the 7th sample; fault=1.
- Go from P2 directly to P4 -> err_sequence=1; assert clr_err the next cycle -> the flag returns to 0.
- Drive light_S=001 with light_M1=001 for one sample -> err_conflict=1 and phase=0 together; locked=0.
- Drive light_MT=011 -> err_encoding=1, phase=0, state SYNC; resume legal patterns -> locked=1 after the next phase change, and the errors stay sticky.
- Assert rst mid-P5 -> all outputs 0 immediately; after release, a legal run reaches locked=1 with no errors.
